booth4_mult_seq: RTL and testbench



---
 rtl/booth4_mult_seq.sv | 126 ++++++++++++
 tb/tb_booth4_mult_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth4_mult_seq.sv
// Sequential radix-4 Booth multiplier: 2 multiplier bits per cycle, start/done handshake.
// Define BOOTH4_UNSIGNED_EN to add the sin_signo port (zero-extended unsigned operands).
module booth4_mult_seq #(
  parameter int SIZE = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inicio,
  input  logic [SIZE-1:0]     multiplicando,
  input  logic [SIZE-1:0]     multiplicador,
`ifdef BOOTH4_UNSIGNED_EN
  input  logic                sin_signo,
`endif
  output logic                listo,
  output logic                fin,
  output logic [2*SIZE-1:0]   producto
);

  localparam int ITER = SIZE/2 + 1;
  localparam int CW   = $clog2(ITER + 1);
  localparam int AW   = SIZE + 3;
  localparam int QW   = SIZE + 2;

  typedef enum logic [1:0] {IDLE, OPER, FIN} state_t;

  state_t          state;
  logic [AW-1:0]   m, m2, a;
  logic [QW-1:0]   q;
  logic            q_m1;
  logic [CW-1:0]   cnt;

  logic            ext_d, ext_r;
  logic [AW-1:0]   m_ext;
  logic [QW-1:0]   q_ext;

`ifdef BOOTH4_UNSIGNED_EN
  assign ext_d = sin_signo ? 1'b0 : multiplicando[SIZE-1];
  assign ext_r = sin_signo ? 1'b0 : multiplicador[SIZE-1];
`else
  assign ext_d = multiplicando[SIZE-1];
  assign ext_r = multiplicador[SIZE-1];
`endif

  assign m_ext = {{3{ext_d}}, multiplicando};
  assign q_ext = {{2{ext_r}}, multiplicador};

  // Booth digit decode: pick 0, M or 2M and whether to subtract
  logic            sel_2m, sub, nz;
  logic [AW-1:0]   operand, addend, a_sum, a_nx;
  logic [QW-1:0]   q_nx;
  logic [AW+QW-1:0] aq_nx;

  always_comb begin
    sel_2m = 1'b0;
    sub    = 1'b0;
    nz     = 1'b1;
    case ({q[1:0], q_m1})
      3'b000, 3'b111: nz = 1'b0;
      3'b011:         sel_2m = 1'b1;
      3'b100:         begin sel_2m = 1'b1; sub = 1'b1; end
      3'b101, 3'b110: sub = 1'b1;
      default:        ;
    endcase
  end

  // Subtract as invert plus carry-in on the single adder
  assign operand = nz ? (sel_2m ? m2 : m) : '0;
  assign addend  = sub ? ~operand : operand;
  assign a_sum   = a + addend + AW'(sub);

  assign a_nx  = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
  assign q_nx  = {a_sum[1:0], q[QW-1:2]};
  assign aq_nx = {a_nx, q_nx};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      listo    <= 1'b1;
      fin      <= 1'b0;
      producto <= '0;
      m        <= '0;
      m2       <= '0;
      a        <= '0;
      q        <= '0;
      q_m1     <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inicio) begin
            m     <= m_ext;
            m2    <= {m_ext[AW-2:0], 1'b0};
            q     <= q_ext;
            a     <= '0;
            q_m1  <= 1'b0;
            cnt   <= CW'(ITER);
            listo <= 1'b0;
            state <= OPER;
          end
        end
        OPER: begin
          a    <= a_nx;
          q    <= q_nx;
          q_m1 <= q[1];
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            producto <= aq_nx[2*SIZE-1:0];
            fin      <= 1'b1;
            state    <= FIN;
          end
        end
        FIN: begin
          fin   <= 1'b0;
          listo <= 1'b1;
          state <= IDLE;
        end
        default: begin
          fin   <= 1'b0;
          listo <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth4_mult_seq.sv
// Bench for booth4_mult_seq: vector table, handshake corner cases and a
// back-to-back random stream checked through an expected-product queue.
module tb_booth4_mult_seq;

  localparam int SIZE = 8;
  localparam int ITER = SIZE/2 + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              inicio = 1'b0;
  logic [SIZE-1:0]   multiplicando = '0;
  logic [SIZE-1:0]   multiplicador = '0;
  logic              sin_signo = 1'b0;
  logic              listo, fin;
  logic [2*SIZE-1:0] producto;

  booth4_mult_seq #(.SIZE(SIZE)) dut (
    .clk(clk),
    .reset(reset),
    .inicio(inicio),
    .multiplicando(multiplicando),
    .multiplicador(multiplicador),
`ifdef BOOTH4_UNSIGNED_EN
    .sin_signo(sin_signo),
`endif
    .listo(listo),
    .fin(fin),
    .producto(producto)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_fin = 0;
  int cyc   = 0;
  int last_fin = -1;
  bit b2b = 1'b0;
  logic [2*SIZE-1:0] exp_q[$];

  typedef struct {
    logic [SIZE-1:0]   a;
    logic [SIZE-1:0]   b;
    logic              uns;
    logic [2*SIZE-1:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [2*SIZE-1:0] ref_mul(input logic [SIZE-1:0] a,
                                                input logic [SIZE-1:0] b, input logic uns);
    logic signed [2*SIZE-1:0] sa, sb;
    if (uns) begin
      sa = {{SIZE{1'b0}}, a};
      sb = {{SIZE{1'b0}}, b};
    end else begin
      sa = {{SIZE{a[SIZE-1]}}, a};
      sb = {{SIZE{b[SIZE-1]}}, b};
    end
    return sa * sb;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every fin pops one expected product
  always @(posedge clk) begin
    #1;
    if (fin) begin
      n_fin++;
      if (exp_q.size() == 0) begin
        check("spurious_fin", 32'(producto), 32'hDEAD_BEEF);
      end else begin
        check("producto", 32'(producto), 32'(exp_q.pop_front()));
      end
      if (b2b && last_fin >= 0) check("fin_spacing", 32'(cyc - last_fin), 32'(ITER + 2));
      last_fin = cyc;
    end
  end

  task automatic wait_listo();
    int n = 0;
    while (!listo && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!listo) check("listo_timeout", 32'(listo), 32'd1);
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge
  task automatic start(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                       input logic uns, input bit expect_result);
    wait_listo();
    multiplicando = a;
    multiplicador = b;
    sin_signo     = uns;
    inicio        = 1'b1;
    @(posedge clk);
    if (expect_result) exp_q.push_back(ref_mul(a, b, uns));
    #1;
    inicio = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int fin_at;
    bit listo_low;
    int fins0;

    vecs.push_back('{8'hFD, 8'h05, 1'b0, 16'hFFF1});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 16'h4000});
    vecs.push_back('{8'h7F, 8'h80, 1'b0, 16'hC080});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 16'h0000});
    vecs.push_back('{8'h03, 8'h04, 1'b0, 16'h000C});
    vecs.push_back('{8'h7F, 8'h7F, 1'b0, 16'h3F01});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'h0001});
`ifdef BOOTH4_UNSIGNED_EN
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'hFE01});
    vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
    vecs.push_back('{8'hFF, 8'h01, 1'b1, 16'h00FF});
`endif

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_listo", 32'(listo), 32'd1);
    check("rst_fin", 32'(fin), 32'd0);
    check("rst_producto", 32'(producto), 32'd0);

    // Table vectors: fixed expectations, one product at a time
    foreach (vecs[i]) begin
      start(vecs[i].a, vecs[i].b, vecs[i].uns, 1'b0);
      exp_q.push_back(vecs[i].exp);
      drain();
    end

    // Latency and listo/fin timing for -3 x 5
    @(posedge clk); #1;
    start(8'hFD, 8'h05, 1'b0, 1'b1);
    fin_at = -1;
    listo_low = 1'b1;
    for (int k = 1; k <= ITER; k++) begin
      if (listo) listo_low = 1'b0;
      if (fin && fin_at < 0) fin_at = k - 1;
      @(posedge clk); #1;
    end
    if (fin && fin_at < 0) fin_at = ITER;
    check("fin_latency", 32'(fin_at), 32'(ITER));
    check("listo_busy_low", 32'(listo_low), 32'd1);
    check("listo_in_fin", 32'(listo), 32'd0);
    @(posedge clk); #1;
    check("listo_back", 32'(listo), 32'd1);
    check("fin_one_cycle", 32'(fin), 32'd0);
    drain();

    // inicio pulses during OPER are ignored
    fins0 = n_fin;
    start(8'h12, 8'h34, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    multiplicando = 8'h55; multiplicador = 8'h55; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    @(posedge clk); #1;
    inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("ignored_inicio_fins", 32'(n_fin - fins0), 32'd1);
    check("ignored_inicio_product", 32'(producto), 32'h03A8);

    // Reset mid-operation discards the product
    start(8'h21, 8'h43, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_listo", 32'(listo), 32'd1);
    check("midrst_fin", 32'(fin), 32'd0);
    check("midrst_producto", 32'(producto), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    start(8'h03, 8'h04, 1'b0, 1'b1);
    drain();
    check("after_rst_3x4", 32'(producto), 32'h000C);

    // Reset and inicio together: reset wins, nothing starts
    reset = 1'b1; inicio = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; inicio = 1'b0;
    @(posedge clk); #1;
    check("rst_beats_inicio", 32'(listo), 32'd1);

    // Back-to-back random stream with inicio held high
    b2b = 1'b1;
    last_fin = -1;
    inicio = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      multiplicando = SIZE'($urandom);
      multiplicador = SIZE'($urandom);
`ifdef BOOTH4_UNSIGNED_EN
      sin_signo = 1'($urandom);
`else
      sin_signo = 1'b0;
`endif
      wait_listo();
      @(posedge clk);
      exp_q.push_back(ref_mul(multiplicando, multiplicador, sin_signo));
      #1;
    end
    inicio = 1'b0;
    drain();
    b2b = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
